sm_2c_conv_pipe: RTL and testbench
==================================

// Module: sm_2c_conv_pipe
// PURPOSE
//  Pipelined, bidirectional sign-magnitude <-> two's-complement converter with valid/ready handshake.
//  Successor to the combinational SM->2C converter: direction is selectable per word, and -0 and
//  most-negative corner cases are flagged. Sits at the operand/result boundary of the Booth radix-4
//  multiplier datapath; sustains 1 word/cycle under full throughput.
// PARAMETERS
//  W       32   data width in bits; legal range W >= 2
// PORTS
//  clk          in   1    clock; all state updates on rising edge
//  rst          in   1    asynchronous, active-high reset
//  in_valid     in   1    input word valid
//  in_ready     out  1    converter can accept a word this cycle
//  in_data      in   W    word to convert
//  in_mode      in   1    0: SM->2C, 1: 2C->SM
//  out_valid    out  1    output word valid
//  out_ready    in   1    downstream accepts the output word
//  out_data     out  W    converted word
//  out_mode     out  1    in_mode that travelled with this word
//  out_negzero  out  1    SM->2C input was -0 (sign=1, magnitude=0)
//  out_ovf      out  1    2C->SM input was 2^(W-1) (10..0), no SM encoding exists
// BEHAVIOUR
//  - Two register stages: S1 captures in_data/in_mode; S2 holds result and flags. Each stage has a valid bit.
//  - Accept when in_valid && in_ready. Accept in cycle N -> out_valid in cycle N+2 (latency 2).
//  - Output handshake: word leaves when out_valid && out_ready. While out_valid && !out_ready,
//    out_data/out_mode/out_negzero/out_ovf stay stable.
//  - Stage advance: S2 loads when S2 empty or draining; S1 loads when S1 empty or moving to S2.
//  - in_ready = !S1_valid || S1 moves this cycle (combinational path from out_ready).
//    Full pipe with out_ready=1: accept and drain in the same cycle, no bubble.
//  - Words are never dropped, duplicated or reordered.
//  - SM->2C (mode 0), s=a[W-1], m=a[W-2:0]:
//    s=0 -> b=a.  s=1, m!=0 -> b = ~{1'b0,m} + 1 (W-bit).  s=1, m=0 -> b=0, out_negzero=1.
//  - 2C->SM (mode 1):
//    a[W-1]=0 -> b=a.  a negative, a != 10..0 -> b = {1'b1, (~a+1)[W-2:0]}.
//    a = 10..0 -> out_ovf=1; b depends on SAT_CONV_EN (see CONFIGURATION).
//  - out_negzero is 0 in mode 1; out_ovf is 0 in mode 0. Flags are valid only with out_valid.
//  - Reset (async): S1/S2 valid=0, out_valid=0, out_data=0, out_mode=0, out_negzero=0, out_ovf=0.
//    in_ready=0 while rst is high, then 1 from the first cycle after release.
//  - Reset mid-operation: all in-flight words are discarded and no output is produced for them.
//    out_valid falls immediately, without waiting for a clock edge.
//  - in_data/in_mode are ignored when in_valid=0 or in_ready=0.
// CONFIGURATION
//  SAT_CONV_EN defined: a 2C->SM input of 10..0 saturates to b = {1'b1, {W-1{1'b1}}}
//    (-(2^(W-1)-1)), with out_ovf=1.
//  SAT_CONV_EN undefined: a 2C->SM input of 10..0 gives b = {1'b1, {W-1{1'b0}}} (SM -0 pattern),
//    with out_ovf=1.
//  All other behaviour is identical in both builds.
// TESTING  (W=8 unless stated)
//  1. mode0 in 0x85, out_ready=1 -> 2 cycles later out_data=0xFB, negzero=0; mode0 0x05 -> 0x05.
//  2. mode0 in 0x80 -> out_data=0x00, out_negzero=1; mode1 in 0xFB -> out_data=0x85, out_ovf=0.
//  3. mode1 in 0x80 -> out_ovf=1; out_data=0xFF with SAT_CONV_EN, 0x80 without; run both builds.
//  4. Stream 0x01..0x06 with alternating modes, out_ready=1 -> one output per cycle, in order,
//     in_ready never falls.
//  5. Stream 5 words, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts.
//     out_data stable while stalled; all 5 outputs correct and in order after release.
//  6. 2 words in flight, pulse rst mid-cycle -> out_valid=0 before the next edge, no stale output.
//     Next accepted word returns after 2 cycles.
//  7. W=32 sweep: random words in both modes -> mode1(mode0(x)) == x for every x except
//     negzero (0x80000000) inputs.

Source files
------------

// File: rtl/sm_2c_conv_pipe.sv
// Two-stage sign-magnitude <-> two's-complement converter with valid/ready flow control.
// Optional build macro: SAT_CONV_EN (2C->SM of the most-negative value saturates instead of giving SM -0).
module sm_2c_conv_pipe #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_mode,
  output logic         out_negzero,
  output logic         out_ovf
);

  localparam logic [W-1:0] ONE = W'(1);

  logic         s1_valid;
  logic [W-1:0] s1_data;
  logic         s1_mode;

  logic         s1_load;
  logic         s2_load;

  logic         sign;
  logic [W-2:0] low;
  logic         low_zero;
  logic [W-1:0] negated;
  logic [W-1:0] conv_data;
  logic         conv_negzero;
  logic         conv_ovf;

  // S2 takes a word whenever it is empty or its word is leaving this cycle.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
      end
      if (s1_load)
        s1_valid <= 1'b1;
      else if (s2_load)
        s1_valid <= 1'b0;
    end
  end

  assign sign     = s1_data[W-1];
  assign low      = s1_data[W-2:0];
  assign low_zero = (low == '0);
  // SM->2C negates the zero-extended magnitude; 2C->SM negates the whole word.
  assign negated  = ~(s1_mode ? s1_data : {1'b0, low}) + ONE;

  always_comb begin
    conv_data    = s1_data;
    conv_negzero = 1'b0;
    conv_ovf     = 1'b0;
    if (sign) begin
      if (!s1_mode) begin
        if (low_zero) begin
          conv_data    = '0;
          conv_negzero = 1'b1;
        end else begin
          conv_data = negated;
        end
      end else begin
        if (low_zero) begin
          conv_ovf = 1'b1;
`ifdef SAT_CONV_EN
          conv_data = {1'b1, {(W-1){1'b1}}};
`else
          conv_data = {1'b1, {(W-1){1'b0}}};
`endif
        end else begin
          conv_data = {1'b1, negated[W-2:0]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_mode    <= 1'b0;
      out_negzero <= 1'b0;
      out_ovf     <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid   <= 1'b1;
        out_data    <= conv_data;
        out_mode    <= s1_mode;
        out_negzero <= conv_negzero;
        out_ovf     <= conv_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm_2c_conv_pipe.sv
// Bench for sm_2c_conv_pipe: W=8 instance for directed/flow tests, W=32 instance for round-trip sweep.
module tb_sm_2c_conv_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       v8, r8, m8, ov8, or8, om8, nz8, of8;
  logic [7:0] d8, od8;
  logic        v32, r32, m32, ov32, or32, om32, nz32, of32;
  logic [31:0] d32, od32;

  sm_2c_conv_pipe #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_data(d8), .in_mode(m8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_mode(om8),
    .out_negzero(nz8), .out_ovf(of8));

  sm_2c_conv_pipe #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_data(d32), .in_mode(m32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_mode(om32),
    .out_negzero(nz32), .out_ovf(of32));

`ifdef SAT_CONV_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic        m;
    logic        nz;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] smp_d;
  logic smp_v, smp_m, smp_nz, smp_ovf, acc, fire;

  // Reference: values interpreted as integers, conversion done by arithmetic on magnitudes.
  function automatic exp_t ref_conv(input longint a, input bit mode, input int w);
    longint full, half, mag;
    exp_t e;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    e.d = '0; e.m = mode; e.nz = 1'b0; e.ovf = 1'b0;
    if (a < half) begin
      e.d = 32'(a);
    end else if (!mode) begin
      mag = a - half;
      if (mag == 0) e.nz = 1'b1;
      else e.d = 32'(full - mag);
    end else begin
      mag = full - a;
      if (mag == half) begin
        e.ovf = 1'b1;
        e.d = SAT ? 32'(full - 1) : 32'(half);
      end else begin
        e.d = 32'(half + mag);
      end
    end
    return e;
  endfunction

  task automatic cyc8(input bit iv, input logic [7:0] d, input bit m, input bit ordy);
    @(negedge clk);
    v8 = iv; d8 = d; m8 = m; or8 = ordy;
    #2;
    acc = v8 && r8;
    fire = ov8 && or8;
    smp_v = ov8; smp_d = od8; smp_m = om8; smp_nz = nz8; smp_ovf = of8;
    if (acc) q8.push_back(ref_conv(longint'(d), m, 8));
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v8 = 0; d8 = 0; m8 = 0; or8 = 0;
    v32 = 0; d32 = 0; m32 = 0; or32 = 0;
    #12;
    checks++;
    if ({ov8, od8, om8, nz8, of8, r8, ov32, r32} !== '0) begin
      failures++;
      $display("FAIL reset_state: got ov=%b data=%h mode=%b nz=%b ovf=%b rdy=%b ov32=%b rdy32=%b, want all 0",
               ov8, od8, om8, nz8, of8, r8, ov32, r32);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if (r8 !== 1'b1 || r32 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b/%b, want 1/1", r8, r32);
    end
    q8.delete();
  endtask

  task automatic directed(input string name, input logic [7:0] d, input bit m,
                          input logic [7:0] xd, input bit xnz, input bit xovf);
    cyc8(1'b1, d, m, 1'b1);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: in_ready got %b, want 1", name, acc);
    end
    cyc8(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (fire !== 1'b0) begin
      failures++;
      $display("FAIL %s_latency: out_valid one cycle after accept got %b, want 0", name, fire);
    end
    cyc8(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (fire !== 1'b1 || {smp_d, smp_m, smp_nz, smp_ovf} !== {xd, m, xnz, xovf}) begin
      failures++;
      $display("FAIL %s_result: got v=%b data=%h mode=%b nz=%b ovf=%b, want v=1 data=%h mode=%b nz=%b ovf=%b",
               name, fire, smp_d, smp_m, smp_nz, smp_ovf, xd, m, xnz, xovf);
    end
    q8.delete();
  endtask

  task automatic test_sm_to_2c();
    directed("sm2c_neg", 8'h85, 1'b0, 8'hFB, 1'b0, 1'b0);
    directed("sm2c_pos", 8'h05, 1'b0, 8'h05, 1'b0, 1'b0);
    directed("sm2c_negzero", 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_2c_to_sm();
    directed("2csm_neg", 8'hFB, 1'b1, 8'h85, 1'b0, 1'b0);
    directed("2csm_pos", 8'h7F, 1'b1, 8'h7F, 1'b0, 1'b0);
    directed("2csm_minneg", 8'h80, 1'b1, SAT ? 8'hFF : 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_stream();
    exp_t e;
    int nout = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        cyc8(1'b1, 8'(i + 1), i[0], 1'b1);
        checks++;
        if (acc !== 1'b1) begin
          failures++;
          $display("FAIL stream_ready: cycle %0d in_ready got %b, want 1", i, acc);
        end
      end else begin
        cyc8(1'b0, 8'h00, 1'b0, 1'b1);
      end
      if (fire) begin
        nout++;
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: got data=%h, want no output", smp_d);
        end else begin
          e = q8.pop_front();
          if ({smp_d, smp_m, smp_nz, smp_ovf} !== {e.d[7:0], e.m, e.nz, e.ovf}) begin
            failures++;
            $display("FAIL stream_data: got %h/%b/%b/%b, want %h/%b/%b/%b",
                     smp_d, smp_m, smp_nz, smp_ovf, e.d[7:0], e.m, e.nz, e.ovf);
          end
        end
      end
    end
    checks++;
    if (nout != 6) begin
      failures++;
      $display("FAIL stream_count: got %0d outputs in 8 cycles, want 6", nout);
    end
    q8.delete();
  endtask

  task automatic test_stall();
    logic [7:0] w[6];
    bit wm[6];
    exp_t e;
    int sent = 0, nout = 0, budget = 0;
    for (int i = 0; i < 6; i++) begin
      w[i] = 8'($urandom);
      wm[i] = 1'($urandom);
    end
    for (int c = 0; c < 4; c++) begin
      cyc8(1'b1, w[sent], wm[sent], 1'b0);
      if (acc) sent++;
      if (c >= 2) begin
        checks++;
        if (acc !== 1'b0 || smp_v !== 1'b1 || q8.size() == 0 || smp_d !== q8[0].d[7:0]) begin
          failures++;
          $display("FAIL stall_hold: cycle %0d got rdy=%b v=%b data=%h, want rdy=0 v=1 data=%h",
                   c, acc, smp_v, smp_d, (q8.size() > 0) ? q8[0].d[7:0] : 8'h00);
        end
      end
    end
    checks++;
    if (sent != 2) begin
      failures++;
      $display("FAIL stall_accepts: got %0d accepts while stalled, want 2", sent);
    end
    while ((sent < 5 || q8.size() > 0) && budget < 20) begin
      budget++;
      cyc8(sent < 5, w[sent], wm[sent], 1'b1);
      if (acc) sent++;
      if (fire) begin
        nout++;
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL stall_extra: got data=%h, want no output", smp_d);
        end else begin
          e = q8.pop_front();
          if ({smp_d, smp_m, smp_nz, smp_ovf} !== {e.d[7:0], e.m, e.nz, e.ovf}) begin
            failures++;
            $display("FAIL stall_data: got %h/%b/%b/%b, want %h/%b/%b/%b",
                     smp_d, smp_m, smp_nz, smp_ovf, e.d[7:0], e.m, e.nz, e.ovf);
          end
        end
      end
    end
    checks++;
    if (nout != 5 || sent != 5) begin
      failures++;
      $display("FAIL stall_drain: got %0d outputs %0d accepts, want 5 and 5", nout, sent);
    end
    q8.delete();
  endtask

  task automatic test_reset_mid();
    cyc8(1'b1, 8'h85, 1'b0, 1'b0);
    cyc8(1'b1, 8'hFB, 1'b1, 1'b0);
    @(negedge clk);
    v8 = 1'b0; or8 = 1'b0;
    #2;
    checks++;
    if (ov8 !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_inflight: out_valid got %b, want 1", ov8);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ov8 !== 1'b0 || r8 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: got out_valid=%b in_ready=%b, want 0/0", ov8, r8);
    end
    #1;
    rst = 1'b0;
    q8.delete();
    for (int i = 0; i < 3; i++) begin
      cyc8(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (fire !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_stale: cycle %0d got output data=%h, want none", i, smp_d);
      end
    end
    directed("rstmid_next", 8'h05, 1'b0, 8'h05, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    exp_t e;
    int budget = 0;
    for (int i = 0; i < 300; i++) begin
      cyc8(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7));
      if (fire) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL random_extra: got data=%h, want no output", smp_d);
        end else begin
          e = q8.pop_front();
          if ({smp_d, smp_m, smp_nz, smp_ovf} !== {e.d[7:0], e.m, e.nz, e.ovf}) begin
            failures++;
            $display("FAIL random_data: got %h/%b/%b/%b, want %h/%b/%b/%b",
                     smp_d, smp_m, smp_nz, smp_ovf, e.d[7:0], e.m, e.nz, e.ovf);
          end
        end
      end
    end
    while (q8.size() > 0 && budget < 10) begin
      budget++;
      cyc8(1'b0, 8'h00, 1'b0, 1'b1);
      if (fire) begin
        e = q8.pop_front();
        checks++;
        if ({smp_d, smp_m, smp_nz, smp_ovf} !== {e.d[7:0], e.m, e.nz, e.ovf}) begin
          failures++;
          $display("FAIL random_drain: got %h/%b/%b/%b, want %h/%b/%b/%b",
                   smp_d, smp_m, smp_nz, smp_ovf, e.d[7:0], e.m, e.nz, e.ovf);
        end
      end
    end
    checks++;
    if (q8.size() != 0) begin
      failures++;
      $display("FAIL random_lost: got %0d words missing, want 0", q8.size());
    end
  endtask

  task automatic conv32(input logic [31:0] a, input bit m, output logic [31:0] b,
                        output bit nz, output bit ovf, output bit ok);
    ok = 1'b0; b = '0; nz = 1'b0; ovf = 1'b0;
    @(negedge clk);
    v32 = 1'b1; d32 = a; m32 = m; or32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    for (int k = 0; k < 4 && !ok; k++) begin
      #2;
      if (ov32) begin
        b = od32; nz = nz32; ovf = of32; ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_roundtrip32();
    logic [31:0] sp[4];
    logic [31:0] x, y, z;
    bit nz1, of1, nz2, of2, ok1, ok2;
    exp_t e;
    sp[0] = 32'h0000_0000; sp[1] = 32'h7FFF_FFFF; sp[2] = 32'h8000_0001; sp[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      x = (i < 4) ? sp[i] : $urandom;
      if (x == 32'h8000_0000) x = 32'h0000_1234;
      conv32(x, 1'b0, y, nz1, of1, ok1);
      conv32(y, 1'b1, z, nz2, of2, ok2);
      e = ref_conv(longint'(x), 1'b0, 32);
      checks++;
      if (!ok1 || !ok2) begin
        failures++;
        $display("FAIL rt32_timeout: x=%h got ok=%b/%b, want 1/1", x, ok1, ok2);
      end else if ({y, nz1, of1} !== {e.d, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL rt32_fwd: x=%h got %h nz=%b ovf=%b, want %h nz=0 ovf=0", x, y, nz1, of1, e.d);
      end
      checks++;
      if ({z, nz2, of2} !== {x, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL rt32_back: x=%h got %h nz=%b ovf=%b, want %h nz=0 ovf=0", x, z, nz2, of2, x);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sm_to_2c();
    test_2c_to_sm();
    test_stream();
    test_stall();
    test_reset_mid();
    test_random();
    test_roundtrip32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
